tdm_mux4: RTL and testbench
===========================

# tdm_mux4

Four-lane time-division multiplexer: the transmit end of the 1:4 lane-select interface (y, s1, s0 in; a, b, c, d out). It captures four parallel lanes as one coherent frame. It then serialises them onto a single lane `y` over four slots, driving `s1`/`s0` so a downstream 1:4 demux routes each slot to the matching output. Downstream `ready` can stall slot advance.

## Interface
- `WIDTH`, 1, width of each lane and of `y`
- `clk`  in  1  sole clock, rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `en`  in  1  request to transmit frames; sampled at frame boundaries
- `ready`  in  1  downstream accepts current slot this cycle
- `a`, `b`, `c`, `d`  in  WIDTH  parallel lanes, slots 0..3
- `y`  out  WIDTH  serialised lane data (registered)
- `s1`, `s0`  out  1  slot index of `y`, {s1,s0} = 0..3 (registered)
- `valid`  out  1  `y`/`s1`/`s0` carry a live slot
- `frame`  out  1  high while slot 0 is presented
- `parity`  out  WIDTH  only with `TDM_PARITY_EN`, see Configuration

## Operation
- Reset values: `y`=0, `s1`=0, `s0`=0, `valid`=0, `frame`=0, `parity`=0, state IDLE, holding register 0.
- Two states, IDLE and RUN. The slot counter is 2 bits and is exposed as {s1,s0}.
- IDLE: when `en`=1 at an edge, capture a/b/c/d into the holding register and enter RUN with slot 0.
  - Outputs for slot 0: `y`=captured a, {s1,s0}=00, `valid`=1, `frame`=1.
  - `ready` is ignored in IDLE.
- RUN with `ready`=0: all outputs and the holding register hold (stall).
- RUN with `ready`=1 and slot < 3: advance the slot. `y` is the captured lane for the new slot. `frame`=0.
- RUN with `ready`=1 and slot 3 (end of frame):
  - `en`=1: recapture the lanes, slot 0, `frame`=1, `valid` stays 1. Back-to-back frames have no gap.
  - `en`=0: go to IDLE. `valid`=0, `y`=0, {s1,s0}=00, `frame`=0.
- `en` is sampled only in IDLE and at the slot-3 accept. Deasserting `en` mid-frame never truncates a frame.
- Lane inputs are sampled only at capture. Changes mid-frame do not affect the frame in flight.
- Counter wraps 3→0 only via the end-of-frame rule. No other wrap exists.

## Timing
- Latency: from an `en` sample in IDLE to slot 0 on the outputs is 1 edge. Each accepted slot takes 1 cycle.
- With `ready` tied high, a frame occupies exactly 4 cycles.
- A slot is transferred on any edge where `valid`=1 and `ready`=1.
- Outputs are fully registered. There is no combinational path from any input to any output.
- Reset mid-frame: all outputs clear immediately, asynchronously. The partial frame is discarded.
  - The first edge after `rst_n` rises treats the block as IDLE.

## Configuration
- `TDM_PARITY_EN` defined:
  - Port `parity` exists. It equals a^b^c^d of the captured frame.
  - It is registered at capture and held for all four slots of that frame.
  - It goes to 0 on the transition to IDLE.
- `TDM_PARITY_EN` undefined: port `parity` and its register are absent. All other behaviour is identical.

## Test plan
- Basic frame, WIDTH=1, reset then a,b,c,d=1,0,1,1, `en`=1 one cycle, `ready`=1 → over four cycles y=1,0,1,1 with {s1,s0}=00,01,10,11. `frame`=1 only on the first cycle. `valid`=0 from the fifth cycle.
- Stall, WIDTH=4, lanes 4'hA,4'h5,4'h3,4'hC, `ready` low for 3 cycles during slot 1 → y=4'h5, {s1,s0}=01 held for those 3 cycles, then slots 2, 3 follow normally.
- Back-to-back, `en` held 1, lanes changed to 0,1,0,0 during slot 2 → first frame unchanged. Next frame starts the cycle after slot 3 with no gap and carries 0,1,0,0.
- Mid-frame `en` drop: `en`=0 during slot 1 → slots 2 and 3 still emitted, then IDLE.
- Async reset at slot 2 → y, s1, s0, valid and frame are 0 before the next clock edge. The block restarts only on a fresh `en`.
- With `TDM_PARITY_EN`, WIDTH=4, lanes 4'h1,4'h2,4'h4,4'h8 → parity=4'hF for all four slots, then 0 in IDLE.

Source files
------------

// File: rtl/tdm_mux4.sv
// tdm_mux4: captures four parallel lanes as one frame and serialises them onto y over slots 0..3 (slot index on {s1,s0}).
// Latency: 1 edge from en sampled in IDLE to slot 0 on the outputs; 1 cycle per accepted slot; back-to-back frames have no gap.
// Backpressure: ready=0 in RUN freezes every output and the holding register; ready is ignored in IDLE.
// Optional feature: define TDM_PARITY_EN to add the parity output (a^b^c^d of the captured frame).
module tdm_mux4 #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] y,
  output logic             s1,
  output logic             s0,
  output logic             valid,
  output logic             frame
`ifdef TDM_PARITY_EN
  ,
  output logic [WIDTH-1:0] parity
`endif
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [1:0]            slot_q, slot_d;
  logic [3:0][WIDTH-1:0] hold_q, hold_d;
  logic [WIDTH-1:0]      y_q, y_d;
  logic                  valid_q, valid_d;
  logic                  frame_q, frame_d;
`ifdef TDM_PARITY_EN
  logic [WIDTH-1:0]      par_q, par_d;
`endif

  logic       eof;
  logic       load;
  logic [1:0] slot_nxt;

  // Slot 3 accepted this edge: the only point (besides IDLE) where en is looked at.
  assign eof      = (state_q == ST_RUN) && ready && (slot_q == 2'd3);
  assign load     = en && ((state_q == ST_IDLE) || eof);
  assign slot_nxt = slot_q + 2'd1;

  // Next-state: capture a new frame, retire to IDLE, advance a slot, or hold on stall.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    hold_d  = hold_q;
    y_d     = y_q;
    valid_d = valid_q;
    frame_d = frame_q;
`ifdef TDM_PARITY_EN
    par_d   = par_q;
`endif
    if (load) begin
      // Lane order in the holding register matches slot index: [0]=a .. [3]=d.
      hold_d  = {d, c, b, a};
      state_d = ST_RUN;
      slot_d  = 2'd0;
      y_d     = a;
      valid_d = 1'b1;
      frame_d = 1'b1;
`ifdef TDM_PARITY_EN
      par_d   = a ^ b ^ c ^ d;
`endif
    end else if (eof) begin
      // Frame done and no new request: drop to an all-zero idle presentation.
      state_d = ST_IDLE;
      slot_d  = 2'd0;
      y_d     = '0;
      valid_d = 1'b0;
      frame_d = 1'b0;
`ifdef TDM_PARITY_EN
      par_d   = '0;
`endif
    end else if ((state_q == ST_RUN) && ready) begin
      slot_d  = slot_nxt;
      y_d     = hold_q[slot_nxt];
      frame_d = 1'b0;
    end
  end

  // State and output registers; reset discards any partial frame at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      slot_q  <= 2'd0;
      hold_q  <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      frame_q <= 1'b0;
`ifdef TDM_PARITY_EN
      par_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      hold_q  <= hold_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      frame_q <= frame_d;
`ifdef TDM_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign y     = y_q;
  assign s1    = slot_q[1];
  assign s0    = slot_q[0];
  assign valid = valid_q;
  assign frame = frame_q;
`ifdef TDM_PARITY_EN
  assign parity = par_q;
`endif

endmodule

// File: tb/tb_tdm_mux4.sv
// Bench for tdm_mux4 (WIDTH=4): directed cycle table, async-reset sequence, then random traffic
// checked against a slot-queue reference model. Parity is checked when TDM_PARITY_EN is defined.
module tb_tdm_mux4;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       ready;
  logic [3:0] a, b, c, d;
  logic [3:0] y;
  logic       s1, s0, valid, frame;
`ifdef TDM_PARITY_EN
  logic [3:0] parity;
`endif

  int checks;
  int failures;

  tdm_mux4 #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .ready (ready),
    .a     (a),
    .b     (b),
    .c     (c),
    .d     (d),
    .y     (y),
    .s1    (s1),
    .s0    (s0),
    .valid (valid),
    .frame (frame)
`ifdef TDM_PARITY_EN
    ,
    .parity(parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       rdy;
    logic [3:0] la, lb, lc, ld;
    logic [3:0] ey;
    logic [1:0] es;
    logic       ev;
    logic       ef;
    logic [3:0] ep;
  } vec_t;

  vec_t tbl[$];

  // Reference model: the slots still to be presented, front = slot on the outputs.
  logic [3:0] mq[$];
  logic [3:0] mpar;

  task automatic add(input logic e, input logic r, input logic [3:0] ia, ib, ic, id,
                     input logic [3:0] ey, input logic [1:0] es, input logic ev, input logic ef,
                     input logic [3:0] ep);
    vec_t v;
    v.en = e; v.rdy = r; v.la = ia; v.lb = ib; v.lc = ic; v.ld = id;
    v.ey = ey; v.es = es; v.ev = ev; v.ef = ef; v.ep = ep;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ey, input logic [1:0] es,
                         input logic ev, input logic ef, input logic [3:0] ep);
    chk({tag, "_y"}, y, ey);
    chk({tag, "_slot"}, {2'b00, s1, s0}, {2'b00, es});
    chk({tag, "_valid"}, {3'b000, valid}, {3'b000, ev});
    chk({tag, "_frame"}, {3'b000, frame}, {3'b000, ef});
`ifdef TDM_PARITY_EN
    chk({tag, "_parity"}, parity, ep);
`endif
  endtask

  // Drive inputs at the falling edge, let one rising edge pass, then settle.
  task automatic step(input logic e, input logic r, input logic [3:0] ia, ib, ic, id);
    @(negedge clk);
    en = e; ready = r; a = ia; b = ib; c = ic; d = id;
    @(posedge clk);
    #1;
  endtask

  task automatic model_edge(input logic e, input logic r, input logic [3:0] ia, ib, ic, id);
    if (mq.size() == 0) begin
      if (e) begin
        mq = '{ia, ib, ic, id};
        mpar = ia ^ ib ^ ic ^ id;
      end
    end else if (r) begin
      void'(mq.pop_front());
      if (mq.size() == 0 && e) begin
        mq = '{ia, ib, ic, id};
        mpar = ia ^ ib ^ ic ^ id;
      end
    end
  endtask

  initial begin
    logic       re, rr;
    logic [3:0] ra, rb, rc, rd;
    logic       mv;
    checks = 0;
    failures = 0;
    rst_n = 1'b0; en = 1'b0; ready = 1'b0; a = '0; b = '0; c = '0; d = '0;

    // Basic frame 1,0,1,1 then idle
    add(1,1, 4'h1,4'h0,4'h1,4'h1, 4'h1,2'd0,1,1,4'h1);
    add(0,1, 4'h0,4'h0,4'h0,4'h0, 4'h0,2'd1,1,0,4'h1);
    add(0,1, 4'h0,4'h0,4'h0,4'h0, 4'h1,2'd2,1,0,4'h1);
    add(0,1, 4'h0,4'h0,4'h0,4'h0, 4'h1,2'd3,1,0,4'h1);
    add(0,1, 4'h0,4'h0,4'h0,4'h0, 4'h0,2'd0,0,0,4'h0);
    add(0,1, 4'h0,4'h0,4'h0,4'h0, 4'h0,2'd0,0,0,4'h0);
    // Stall three cycles on slot 1 (lanes A,5,3,C; parity 0)
    add(1,1, 4'hA,4'h5,4'h3,4'hC, 4'hA,2'd0,1,1,4'h0);
    add(0,1, 4'h0,4'h0,4'h0,4'h0, 4'h5,2'd1,1,0,4'h0);
    add(0,0, 4'h0,4'h0,4'h0,4'h0, 4'h5,2'd1,1,0,4'h0);
    add(0,0, 4'h0,4'h0,4'h0,4'h0, 4'h5,2'd1,1,0,4'h0);
    add(0,0, 4'h0,4'h0,4'h0,4'h0, 4'h5,2'd1,1,0,4'h0);
    add(0,1, 4'h0,4'h0,4'h0,4'h0, 4'h3,2'd2,1,0,4'h0);
    add(0,1, 4'h0,4'h0,4'h0,4'h0, 4'hC,2'd3,1,0,4'h0);
    add(0,1, 4'h0,4'h0,4'h0,4'h0, 4'h0,2'd0,0,0,4'h0);
    // Back-to-back with lanes changed mid-frame, then en dropped during slot 1
    add(1,1, 4'h9,4'h6,4'hE,4'h7, 4'h9,2'd0,1,1,4'h6);
    add(1,1, 4'h9,4'h6,4'hE,4'h7, 4'h6,2'd1,1,0,4'h6);
    add(1,1, 4'h9,4'h6,4'hE,4'h7, 4'hE,2'd2,1,0,4'h6);
    add(1,1, 4'h0,4'h1,4'h0,4'h0, 4'h7,2'd3,1,0,4'h6);
    add(1,1, 4'h0,4'h1,4'h0,4'h0, 4'h0,2'd0,1,1,4'h1);
    add(1,1, 4'h0,4'h1,4'h0,4'h0, 4'h1,2'd1,1,0,4'h1);
    add(0,1, 4'h0,4'h1,4'h0,4'h0, 4'h0,2'd2,1,0,4'h1);
    add(0,1, 4'h0,4'h1,4'h0,4'h0, 4'h0,2'd3,1,0,4'h1);
    add(0,1, 4'h0,4'h1,4'h0,4'h0, 4'h0,2'd0,0,0,4'h0);
    // ready ignored in IDLE; parity frame 1,2,4,8
    add(1,0, 4'h1,4'h2,4'h4,4'h8, 4'h1,2'd0,1,1,4'hF);
    add(0,1, 4'h0,4'h0,4'h0,4'h0, 4'h2,2'd1,1,0,4'hF);
    add(0,1, 4'h0,4'h0,4'h0,4'h0, 4'h4,2'd2,1,0,4'hF);
    add(0,1, 4'h0,4'h0,4'h0,4'h0, 4'h8,2'd3,1,0,4'hF);
    add(0,1, 4'h0,4'h0,4'h0,4'h0, 4'h0,2'd0,0,0,4'h0);

    // Reset state
    #12;
    chk_out("reset", 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      step(tbl[i].en, tbl[i].rdy, tbl[i].la, tbl[i].lb, tbl[i].lc, tbl[i].ld);
      chk_out($sformatf("vec%0d", i), tbl[i].ey, tbl[i].es, tbl[i].ev, tbl[i].ef, tbl[i].ep);
    end

    // Async reset while slot 2 is presented
    step(1, 1, 4'h3, 4'h6, 4'h9, 4'hC);
    step(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    step(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    chk_out("pre_rst", 4'h9, 2'd2, 1'b1, 1'b0, 4'h0);
    #2 rst_n = 1'b0;
    #1;
    chk_out("async_rst", 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 4'h0, 4'h0, 4'h0, 4'h0);
    chk_out("post_rst_idle", 4'h0, 2'd0, 1'b0, 1'b0, 4'h0);
    step(1, 1, 4'hB, 4'h4, 4'h2, 4'h1);
    chk_out("restart", 4'hB, 2'd0, 1'b1, 1'b1, 4'hC);

    // Random traffic against the slot-queue model, from a clean reset
    @(negedge clk);
    en = 1'b0;
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    mq.delete();
    mpar = '0;
    for (int i = 0; i < 1500; i++) begin
      re = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 3) != 0);
      ra = 4'($urandom); rb = 4'($urandom); rc = 4'($urandom); rd = 4'($urandom);
      model_edge(re, rr, ra, rb, rc, rd);
      step(re, rr, ra, rb, rc, rd);
      mv = (mq.size() != 0);
      chk_out("rand", mv ? mq[0] : 4'h0, mv ? 2'(4 - mq.size()) : 2'd0, mv,
              (mq.size() == 4), mv ? mpar : 4'h0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
